// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencer.
package traffic_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR2   = 3'd5
  } phase_t;

  // Light head encoding {red,yellow,green}
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Light pattern {main,side} shown in a given phase
  function automatic logic [5:0] heads(input phase_t p);
    logic [5:0] h;
    case (p)
      MAIN_G:  h = {LT_GRN, LT_RED};
      MAIN_Y:  h = {LT_YEL, LT_RED};
      SIDE_G:  h = {LT_RED, LT_GRN};
      SIDE_Y:  h = {LT_RED, LT_YEL};
      default: h = {LT_RED, LT_RED};
    endcase
    return h;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Prescaler: one-cycle strobe every TICK_DIV clocks, on the last count value.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // Free-running counter 0..TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: main road rests on green, side road is
// served after a latched request; drives both heads and a seconds countdown.
import traffic_pkg::*;

module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_MAIN_G = 9,
  parameter int unsigned T_SIDE_G = 6,
  parameter int unsigned T_YEL    = 3,
  parameter int unsigned T_CLR    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             side_sense,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       phase,
  output logic             tick
);

  if (TICK_DIV < 2 ||
      T_MAIN_G < 1 || T_MAIN_G > 15 || T_SIDE_G < 1 || T_SIDE_G > 15 ||
      T_YEL < 1 || T_YEL > 15 || T_CLR < 1 || T_CLR > 15) begin : g_param_check
    $error("traffic_light_ctrl: duration must be 1..15 and TICK_DIV >= 2");
  end

  localparam logic [CNT_W-1:0] C_MAIN_G = CNT_W'(T_MAIN_G);
  localparam logic [CNT_W-1:0] C_SIDE_G = CNT_W'(T_SIDE_G);
  localparam logic [CNT_W-1:0] C_YEL    = CNT_W'(T_YEL);
  localparam logic [CNT_W-1:0] C_CLR    = CNT_W'(T_CLR);

  logic             rst_meta;
  logic             rst_sync;
  phase_t           state;
  phase_t           state_n;
  logic [CNT_W-1:0] cnt_n;
  logic             req_q;
  logic             req_n;
  logic [5:0]       heads_n;

  // Reset asserts immediately, releases two clocks later in the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= '0;
      rst_sync <= '0;
    end else begin
      rst_meta <= '1;
      rst_sync <= rst_meta;
    end
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_sync),
    .tick (tick)
  );

  // Next phase, countdown and request latch; lights decoded from next phase
  // so the registered heads change in the same cycle as phase and count.
  always_comb begin
    state_n = state;
    cnt_n   = count;
    if (tick) begin
      if (count > CNT_W'(1)) begin
        cnt_n = count - CNT_W'(1);
      end else begin
        case (state)
          MAIN_G: begin
            // Without a request the main phase rests at count 1
            if (req_q) begin
              state_n = MAIN_Y;
              cnt_n   = C_YEL;
            end
          end
          MAIN_Y: begin
            state_n = CLR1;
            cnt_n   = C_CLR;
          end
          CLR1: begin
            state_n = SIDE_G;
            cnt_n   = C_SIDE_G;
          end
          SIDE_G: begin
            state_n = SIDE_Y;
            cnt_n   = C_YEL;
          end
          SIDE_Y: begin
            state_n = CLR2;
            cnt_n   = C_CLR;
          end
          default: begin
            state_n = MAIN_G;
            cnt_n   = C_MAIN_G;
          end
        endcase
      end
    end
    // Request is consumed on entry to side green; clear beats a new sense
    req_n   = (state_n == SIDE_G && state != SIDE_G) ? 1'b0 : (req_q | side_sense);
    heads_n = heads(state_n);
  end

  // Phase, countdown, request and light registers
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state      <= MAIN_G;
      count      <= C_MAIN_G;
      req_q      <= '0;
      main_light <= LT_GRN;
      side_light <= LT_RED;
    end else begin
      state                    <= state_n;
      count                    <= cnt_n;
      req_q                    <= req_n;
      {main_light, side_light} <= heads_n;
    end
  end

  assign phase = state;

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Sequencer for a two-road intersection with main and side roads. It drives both light heads and a 4-bit remaining-seconds countdown.
- The countdown feeds the two-digit 7-segment decoder directly, which is why `count` stays in 0..15.
- Main road rests on green. Side road gets green only after a latched vehicle/pedestrian request.
- Contains its own clock prescaler to generate a 1-second tick.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per 1-second tick (≥2; sim uses 4).
- T_MAIN_G, 9, minimum main green seconds (1..15).
- T_SIDE_G, 6, side green seconds (1..15).
- T_YEL, 3, yellow seconds, both roads (1..15).
- T_CLR, 1, all-red clearance seconds (1..15).
- Any duration outside 1..15 or TICK_DIV<2 is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- side_sense  in  1  side-road request (level or pulse, synchronous to clk).
- main_light  out  3  {red,yellow,green} one-hot.
- side_light  out  3  {red,yellow,green} one-hot.
- count  out  4  remaining seconds in current phase, unsigned, to display decoder.
- phase  out  3  current state encoding (debug/observability).
- tick  out  1  one-cycle 1-second strobe (for display blink/testbench).

Behaviour:
Interface:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset asserts immediately and deasserts synchronously to clk via a 2-flop synchronizer internal to the block.

Reset values (also on reset mid-operation, any state):
- phase=MAIN_G, main_light=001, side_light=100, count=T_MAIN_G, tick=0.
- Prescaler=0, request latch=0.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps.
- tick=1 for exactly the one cycle where the counter equals TICK_DIV-1.
- First tick occurs TICK_DIV cycles after reset release.

States and lights (main / side):
- MAIN_G 001/100
- MAIN_Y 010/100
- CLR1 100/100
- SIDE_G 100/001
- SIDE_Y 100/010
- CLR2 100/100

Transitions (evaluated only on tick):
- count>1: count decrements by 1; state holds.
- count==1 and state MAIN_G: if req_q=1, go to MAIN_Y and load T_YEL. Else hold MAIN_G with count held at 1, so minimum green is satisfied and the phase rests.
- count==1 in any other state: advance along MAIN_Y→CLR1→SIDE_G→SIDE_Y→CLR2→MAIN_G, loading T_CLR, T_SIDE_G, T_YEL, T_CLR, T_MAIN_G respectively.

Timing:
- count, phase and lights all update in the same cycle, one clk after the tick cycle (registered outputs).
- count never reads 0 and never wraps.

Request latch req_q:
- req_q_next = (next state is SIDE_G) ? 0 : (req_q | side_sense).
- On the entry cycle into SIDE_G, clear wins over a simultaneous side_sense.
- side_sense during SIDE_G, SIDE_Y or CLR2 is captured, so a new cycle is served after the next minimum main green.

Lights:
- Outputs are decoded from registered state, so they are glitch-free.
- Exactly one bit of each head is high at all times.
- Both heads are never non-red simultaneously.

Decomposition:
Shared package traffic_pkg:
- phase_t state enum: MAIN_G=0, MAIN_Y=1, CLR1=2, SIDE_G=3, SIDE_Y=4, CLR2=5.
- Light constants: LT_RED=100, LT_YEL=010, LT_GRN=001.
- CNT_W=4.

Sub-module:
- tick_gen(TICK_DIV): prescaler producing tick.
- Everything else stays in traffic_light_ctrl.

Test Plan:
All scenarios use TICK_DIV=4 and default durations.
1. Reset, no requests, run 100 ticks. Required: phase stays MAIN_G; count 9,8,…,1 then holds 1; main=001, side=100 throughout.
2. Single-cycle side_sense pulse at tick 2. Required:
   - count reaches 1, then next tick gives MAIN_Y with count=3.
   - Then 3,2,1 → CLR1 with count=1 → SIDE_G with count=6 → SIDE_Y with count=3 → CLR2 with count=1 → MAIN_G with count=9.
   - Full cycle is 23 ticks.
3. side_sense held high continuously. Required:
   - Back-to-back cycles.
   - req_q clears on entering SIDE_G and relatches the next cycle.
   - Main green lasts exactly 9 ticks each cycle.
4. side_sense pulsed coincident with the tick that enters SIDE_G. Required: request is dropped; after return to MAIN_G, phase rests at count=1.
5. rst_n low for 3 cycles asynchronously mid-SIDE_G with count=4. Required:
   - Outputs go to reset values without waiting for clk.
   - First tick comes 4 cycles after release.
6. Every cycle of tests 1–5, assert:
   - main_light and side_light are each one-hot.
   - main_light and side_light are never both non-red.
   - count is in 1..15.
   - tick is high exactly every 4th cycle.
